alu_chain_addsub: RTL and testbench

// Parametrised multi-limb add/subtract engine. Streams operands limb by limb (LSB limb first).

---
 rtl/alu_chain_addsub.sv | 137 +++++++++++++
 tb/tb_alu_chain_addsub.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_chain_addsub.sv
// Multi-limb add/subtract engine: streams WIDTH-bit limbs LSB first, chaining a
// registered carry, and reports {C,Z,N,V} on the last limb of each packet.
module alu_chain_addsub #(
  parameter int WIDTH     = 8,
  parameter int MAX_LIMBS = 4,
  localparam int CW       = (MAX_LIMBS > 1) ? $clog2(MAX_LIMBS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  input  logic [1:0]       mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic [CW-1:0]    out_idx,
  output logic [3:0]       out_flags,
  output logic             len_err
);

  // state   | meaning
  // S_FIRST | next accepted limb starts a packet (mode/cin sampled)
  // S_CHAIN | mid-packet, carry comes from the carry register
  typedef enum logic {S_FIRST, S_CHAIN} state_t;

  state_t           state_q, state_d;
  logic             carry_q, carry_d;
  logic             inv_q, inv_d;
  logic             zacc_q, zacc_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             last_q, last_d;
  logic [CW-1:0]    oidx_q, oidx_d;
  logic [3:0]       flags_q, flags_d;
  logic             lerr_q, lerr_d;

  logic             accept;
  logic             c0;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;
  logic             co;
  logic [WIDTH-1:0] s;
  logic             too_long;
  logic             last_eff;
  logic             v_flag;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    inv_d = inv_q;
    c0    = carry_q;
    if (state_q == S_FIRST) begin
      inv_d = mode[1];
      unique case (mode)
        2'b00:   c0 = 1'b0;
        2'b01:   c0 = cin;
        2'b10:   c0 = 1'b1;
        default: c0 = ~cin;
      endcase
    end
    b_eff    = inv_d ? ~in_b : in_b;
    full     = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c0};
    co       = full[WIDTH];
    s        = full[WIDTH-1:0];
    zacc_d   = ((state_q == S_FIRST) || zacc_q) && (s == '0);
    // An over-length packet is cut here; its tail restarts as a fresh packet.
    too_long = (idx_q == CW'(MAX_LIMBS - 1)) && !in_last;
    last_eff = in_last || too_long;
    v_flag   = (in_a[WIDTH-1] == b_eff[WIDTH-1]) && (s[WIDTH-1] != in_a[WIDTH-1]);

    state_d = state_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    last_d  = last_q;
    oidx_d  = oidx_q;
    flags_d = flags_q;
    lerr_d  = lerr_q;
    if (accept) begin
      state_d = last_eff ? S_FIRST : S_CHAIN;
      carry_d = co;
      idx_d   = last_eff ? '0 : idx_q + 1'b1;
      valid_d = 1'b1;
      sum_d   = s;
      last_d  = last_eff;
      oidx_d  = idx_q;
      flags_d = last_eff ? {co, zacc_d, s[WIDTH-1], v_flag} : 4'b0000;
      lerr_d  = lerr_q || too_long;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FIRST;
      carry_q <= 1'b0;
      inv_q   <= 1'b0;
      zacc_q  <= 1'b1;
      idx_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      oidx_q  <= '0;
      flags_q <= 4'b0000;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      inv_q   <= accept ? inv_d : inv_q;
      zacc_q  <= accept ? zacc_d : zacc_q;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      oidx_q  <= oidx_d;
      flags_q <= flags_d;
      lerr_q  <= lerr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_last  = last_q;
  assign out_idx   = oidx_q;
  assign out_flags = flags_q;
  assign len_err   = lerr_q;

endmodule

// File: tb/tb_alu_chain_addsub.sv
// Table-driven bench for alu_chain_addsub (WIDTH=8, MAX_LIMBS=4) plus
// hand-written stall and mid-packet reset sequences.
module tb_alu_chain_addsub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       in_last = 1'b0;
  logic [1:0] mode = '0;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_sum;
  logic       out_last;
  logic [1:0] out_idx;
  logic [3:0] out_flags;
  logic       len_err;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu_chain_addsub #(.WIDTH(8), .MAX_LIMBS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mode(mode), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_last(out_last), .out_idx(out_idx),
    .out_flags(out_flags), .len_err(len_err)
  );

  typedef struct {
    logic [1:0] mode;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic       last;
    logic [7:0] sum;
    logic       olast;
    logic [1:0] idx;
    logic [3:0] flags;
    logic       lerr;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  // packed view: {valid, last, idx[1:0], flags[3:0], len_err, sum[7:0]}
  function automatic logic [16:0] dut_view();
    return {out_valid, out_last, out_idx, out_flags, len_err, out_sum};
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] m, input logic c, input logic [7:0] a,
                       input logic [7:0] b, input logic l);
    in_valid = 1'b1; mode = m; cin = c; in_a = a; in_b = b; in_last = l;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ADD 0x12FF + 0x0001
    vecs[0]  = '{2'd0, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[1]  = '{2'd0, 1'b0, 8'h12, 8'h00, 1'b1, 8'h13, 1'b1, 2'd1, 4'b0000, 1'b0};
    // SUB 0x0100 - 0x0001
    vecs[2]  = '{2'd2, 1'b0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[3]  = '{2'd2, 1'b0, 8'h01, 8'h00, 1'b1, 8'h00, 1'b1, 2'd1, 4'b1000, 1'b0};
    // SUB 0x0001 - 0x0001
    vecs[4]  = '{2'd2, 1'b0, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[5]  = '{2'd2, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 2'd1, 4'b1100, 1'b0};
    // SBB 0x05 - 0x03 with borrow-in (cin=1 -> c0=0)
    vecs[6]  = '{2'd3, 1'b1, 8'h05, 8'h03, 1'b1, 8'h01, 1'b1, 2'd0, 4'b1000, 1'b0};
    // ADC 0x7F + 0x00 + 1
    vecs[7]  = '{2'd1, 1'b1, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b1, 2'd0, 4'b0011, 1'b0};
    // ADC 0x00FF + 0x0000 + 1; mode/cin on limb 2 must be ignored
    vecs[8]  = '{2'd1, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[9]  = '{2'd2, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b1, 2'd1, 4'b0000, 1'b0};
    // 5 limbs, in_last only on the 5th: 4th is cut, 5th is a new SUB packet
    vecs[10] = '{2'd0, 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[11] = '{2'd0, 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 2'd1, 4'b0000, 1'b0};
    vecs[12] = '{2'd0, 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 2'd2, 4'b0000, 1'b0};
    vecs[13] = '{2'd0, 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b1, 2'd3, 4'b0000, 1'b1};
    vecs[14] = '{2'd2, 1'b0, 8'h01, 8'h01, 1'b1, 8'h00, 1'b1, 2'd0, 4'b1100, 1'b1};

    #2;
    check("reset_outputs", dut_view(), 17'h0);
    check1("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Stall: limb 0 of ADD 0x12FF+0x0001, then hold out_ready low 3 cycles
    @(negedge clk);
    drive(2'd0, 1'b0, 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'd0, 1'b0, 8'h12, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check1("stall_in_ready", in_ready, 1'b0);
      check("stall_hold", dut_view(), {1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_final", dut_view(), {1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 8'h13});
    in_valid = 1'b0;
    @(negedge clk);
    check1("drain_valid", out_valid, 1'b0);

    // Back-to-back vector table at full throughput
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].mode, vecs[i].cin, vecs[i].a, vecs[i].b, vecs[i].last);
      @(negedge clk);
      check($sformatf("vec%0d", i), dut_view(),
            {1'b1, vecs[i].olast, vecs[i].idx, vecs[i].flags, vecs[i].lerr, vecs[i].sum});
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Reset after the first limb of a 2-limb ADD
    drive(2'd0, 1'b0, 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    check("pre_reset_limb", dut_view(), {1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 8'h00});
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_view(), 17'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'd0, 1'b0, 8'h12, 8'h00, 1'b1);
    @(negedge clk);
    // Treated as a first limb: no stale carry, idx 0
    check("post_reset_first", dut_view(), {1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 8'h12});
    in_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
